pulse_stretcher: RTL and testbench

Inverse companion to the button one-pulser: turns single-cycle event pulses back into human-visible levels. Each accepted input pulse produces exactly one output high of HIGH_CYCLES cycles, followed by at least GAP_CYCLES low. Events arriving while a stretched pulse is in progress are queued in a saturating pending counter, so back-to-back pulses stay distinct on LED/debug outputs.

---
 rtl/pulse_pkg.sv | 23 ++
 rtl/sat_updown_counter.sv | 32 +++
 rtl/pulse_stretcher.sv | 119 +++++++++++
 tb/tb_pulse_stretcher.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// Shared types and defaults for the pulse stretcher.
// Used by pulse_stretcher and sat_updown_counter.
package pulse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_GAP
  } stretch_state_t;

  localparam int DEF_HIGH_CYCLES = 4;
  localparam int DEF_GAP_CYCLES  = 2;
  localparam int DEF_PEND_MAX    = 15;

  function automatic int cnt_width(int h, int g);
    int m;
    int w;
    m = (h > g) ? h : g;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sat_updown_counter.sv
// Saturating up/down event counter.
// drop flags an increment lost at MAX.
module sat_updown_counter #(
  parameter int MAX = 15,
  localparam int W = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         drop
);

  logic full;
  logic empty;

  assign full  = (count == W'(MAX));
  assign empty = (count == '0);
  assign drop  = inc && !dec && full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && !dec && !full) begin
      count <= count + 1'b1;
    end else if (dec && !inc && !empty) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches 1-cycle events into HIGH/GAP level pulses, queueing extras.
// Define PULSE_STRETCHER_OVF_EN to add the sticky ovf output.
module pulse_stretcher
  import pulse_pkg::*;
#(
  parameter int HIGH_CYCLES = DEF_HIGH_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int PEND_MAX    = DEF_PEND_MAX,
  localparam int PW = $clog2(PEND_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pulse_in,
  output logic          level_out,
  output logic          busy,
  output logic [PW-1:0] pending
`ifdef PULSE_STRETCHER_OVF_EN
  ,
  output logic          ovf
`endif
);

  localparam int CW = cnt_width(HIGH_CYCLES, GAP_CYCLES);

  stretch_state_t state;
  stretch_state_t state_n;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_n;

  logic work;
  logic start;
  logic inc;
  logic dec;
  logic drop;

  assign work  = pulse_in || (pending != '0);
  assign start = work && ((state == ST_IDLE) ||
                          ((state == ST_GAP) && (cnt == '0)));

  // A start with an empty queue takes the live pulse directly.
  assign dec = start && (pending != '0);
  assign inc = pulse_in && !(start && (pending == '0));

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_HIGH;
          cnt_n   = CW'(HIGH_CYCLES - 1);
        end
      end
      ST_HIGH: begin
        if (cnt == '0) begin
          state_n = ST_GAP;
          cnt_n   = CW'(GAP_CYCLES - 1);
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (start) begin
          state_n = ST_HIGH;
          cnt_n   = CW'(HIGH_CYCLES - 1);
        end else begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs come straight from flops so they never glitch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      level_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      level_out <= (state_n == ST_HIGH);
      busy      <= (state_n != ST_IDLE);
    end
  end

  sat_updown_counter #(
    .MAX(PEND_MAX)
  ) u_pend (
    .clk  (clk),
    .rst  (rst),
    .inc  (inc),
    .dec  (dec),
    .count(pending),
    .drop (drop)
  );

`ifdef PULSE_STRETCHER_OVF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher with an event-schedule model.
// Honours PULSE_STRETCHER_OVF_EN for the ovf checks.
module tb_pulse_stretcher;

  localparam int H  = 4;
  localparam int G  = 2;
  localparam int PM = 3;
  localparam int PW = $clog2(PM + 1);
  localparam int N  = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          pulse_in = 1'b0;
  logic          level_out;
  logic          busy;
  logic [PW-1:0] pending;
`ifdef PULSE_STRETCHER_OVF_EN
  logic          ovf;
`endif

  always #5 clk = ~clk;

  pulse_stretcher #(
    .HIGH_CYCLES(H),
    .GAP_CYCLES (G),
    .PEND_MAX   (PM)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pulse_in (pulse_in),
    .level_out(level_out),
    .busy     (busy),
    .pending  (pending)
`ifdef PULSE_STRETCHER_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  int checks = 0;
  int errors = 0;

  bit stim[N];
  int st[$];
  int ar[$];
  int drop_edge;
  int e_lvl[N], e_busy[N], e_pend[N], e_ovf[N];
  int a_lvl[N], a_busy[N], a_pend[N], a_ovf[N];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Schedule every event: its HIGH starts as soon as the line is free,
  // unless the queue of not-yet-started events is already full.
  function automatic void build_model();
    int f;
    int s;
    int q;
    st.delete();
    ar.delete();
    drop_edge = -1;
    f = 0;
    for (int t = 0; t < N; t++) begin
      if (stim[t]) begin
        s = (t + 1 > f) ? t + 1 : f;
        q = 0;
        foreach (st[i]) if (st[i] > t + 1) q++;
        if (s != t + 1 && q >= PM) begin
          if (drop_edge < 0) drop_edge = t;
        end else begin
          st.push_back(s);
          ar.push_back(t);
          f = s + H + G;
        end
      end
    end
    for (int c = 0; c < N; c++) begin
      e_lvl[c]  = 0;
      e_busy[c] = 0;
      e_pend[c] = 0;
      foreach (st[i]) begin
        if (st[i] <= c && c < st[i] + H) e_lvl[c] = 1;
        if (st[i] <= c && c < st[i] + H + G) e_busy[c] = 1;
        if (ar[i] < c && st[i] > c) e_pend[c]++;
      end
      e_ovf[c] = (drop_edge >= 0 && c > drop_edge) ? 1 : 0;
    end
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    pulse_in = 1'b0;
    rst = 1'b0;
    #1;
    chk("reset_level", level_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_pending", pending, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_test(input string tn, input int lim);
    build_model();
    reset_dut();
    for (int c = 0; c <= lim; c++) begin
      @(negedge clk);
      a_lvl[c]  = int'(level_out);
      a_busy[c] = int'(busy);
      a_pend[c] = int'(pending);
      chk($sformatf("%s_level_c%0d", tn, c), level_out, e_lvl[c]);
      chk($sformatf("%s_busy_c%0d", tn, c), busy, e_busy[c]);
      chk($sformatf("%s_pend_c%0d", tn, c), pending, e_pend[c]);
`ifdef PULSE_STRETCHER_OVF_EN
      a_ovf[c] = int'(ovf);
      chk($sformatf("%s_ovf_c%0d", tn, c), ovf, e_ovf[c]);
`endif
      pulse_in = stim[c];
    end
  endtask

  task automatic set_stim(input int a, input int b);
    for (int i = 0; i < N; i++) stim[i] = (i >= a && i <= b);
  endtask

  int n_rise;
  int max_pend;

  initial begin
    // Single event
    set_stim(10, 10);
    run_test("single", N - 1);
    chk("single_lvl10", a_lvl[10], 0);
    chk("single_lvl11", a_lvl[11], 1);
    chk("single_lvl14", a_lvl[14], 1);
    chk("single_lvl15", a_lvl[15], 0);
    chk("single_busy16", a_busy[16], 1);
    chk("single_busy17", a_busy[17], 0);

    // Three back-to-back events
    set_stim(10, 12);
    run_test("burst3", N - 1);
    chk("burst3_pend12", a_pend[12], 1);
    chk("burst3_pend13", a_pend[13], 2);
    chk("burst3_pend16", a_pend[16], 2);
    chk("burst3_pend17", a_pend[17], 1);
    chk("burst3_pend23", a_pend[23], 0);
    chk("burst3_lvl16", a_lvl[16], 0);
    chk("burst3_lvl17", a_lvl[17], 1);
    chk("burst3_lvl26", a_lvl[26], 1);
    chk("burst3_lvl27", a_lvl[27], 0);

    // Six events: saturate and drop two
    set_stim(10, 15);
    run_test("ovfl", N - 1);
    n_rise = 0;
    for (int c = 1; c < N; c++)
      if (a_lvl[c] == 1 && a_lvl[c-1] == 0) n_rise++;
    chk("ovfl_pulses", n_rise, 4);
    chk("ovfl_pend14", a_pend[14], 3);
    chk("ovfl_lvl29", a_lvl[29], 1);
    chk("ovfl_lvl33", a_lvl[33], 0);
    chk("ovfl_busy34", a_busy[34], 1);
    chk("ovfl_busy35", a_busy[35], 0);
`ifdef PULSE_STRETCHER_OVF_EN
    chk("ovfl_ovf14", a_ovf[14], 0);
    chk("ovfl_ovf15", a_ovf[15], 1);
    chk("ovfl_ovf39", a_ovf[39], 1);
`endif

    // Second event on the final gap cycle
    for (int i = 0; i < N; i++) stim[i] = (i == 10 || i == 16);
    run_test("gapend", N - 1);
    max_pend = 0;
    for (int c = 0; c < N; c++)
      if (a_pend[c] > max_pend) max_pend = a_pend[c];
    chk("gapend_maxpend", max_pend, 0);
    chk("gapend_lvl16", a_lvl[16], 0);
    chk("gapend_lvl17", a_lvl[17], 1);
    chk("gapend_lvl20", a_lvl[20], 1);
    chk("gapend_lvl21", a_lvl[21], 0);

    // Asynchronous reset mid-pulse with two events queued
    set_stim(10, 12);
    run_test("arst", 13);
    chk("arst_pend13", a_pend[13], 2);
    chk("arst_lvl13", a_lvl[13], 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_now_level", level_out, 0);
    chk("arst_now_busy", busy, 0);
    chk("arst_now_pend", pending, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("arst_quiet_level_%0d", c), level_out, 0);
      chk($sformatf("arst_quiet_busy_%0d", c), busy, 0);
      chk($sformatf("arst_quiet_pend_%0d", c), pending, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
